// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spart_pkg
// Description : Types and constants shared by the SPART transmit and receive
//               paths. This file defines the frame FSM state encoding, the
//               oversample ratio and the character width.
// Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

   // Frame FSM states, two-bit encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int OVERSAMPLE = 16;   // baud enables per bit time
   localparam int DATA_BITS  = 8;    // data bits per character

endpackage
`default_nettype wire

// File: rtl/spart_brg.sv
`default_nettype none
// ============================================================================
// Module      : spart_brg
// Description : 16x baud enable generator. A down-counter reloads to divisor
//               when it reaches zero. At that point it pulses baud_en for
//               one clock, which gives a period of divisor+1 clocks. A new
//               divisor value takes effect at the next reload. restart forces
//               an immediate reload so that a new frame starts on a full
//               period.
// Ports       : clk     - system clock
//               rst     - synchronous active-high reset
//               divisor - reload value (period = divisor+1 clocks)
//               restart - force reload, suppresses baud_en this cycle
//               baud_en - one-clock enable pulse
// Revision    : 1.0 - initial release
// ============================================================================
module spart_brg #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] divisor,
   input  logic             restart,
   output logic             baud_en
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q - DIV_W'(1);
      if (restart || (cnt_q == '0)) begin
         cnt_d = divisor;
      end
   end

   // A restart cycle must not also count as a bit tick.
   assign baud_en = (cnt_q == '0) && !restart;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : spart_tx_serializer
// Description : SPART transmit path. It takes one byte into a holding buffer
//               and shifts the byte out as an 8N1 frame on txd. A byte held
//               in the buffer when a stop bit ends starts the next frame
//               directly, so back-to-back frames have no gap between them.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               divisor         - baud divisor (bit = 16*(divisor+1) clocks)
//               tx_data, tx_wr  - byte and single-cycle write strobe
//               tbr             - holding buffer empty
//               tx_busy         - frame in progress
//               tx_ovr, ovr_clr - sticky overrun flag and its clear
//               txd             - registered serial output, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module spart_tx_serializer
   import spart_pkg::*;
#(
   parameter int DIV_W     = 16,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] divisor,
   input  logic [7:0]       tx_data,
   input  logic             tx_wr,
   output logic             tbr,
   output logic             tx_busy,
   output logic             tx_ovr,
   input  logic             ovr_clr,
   output logic             txd
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   tx_state_t         state_q, state_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        buf_q, buf_d;
   logic              full_q, full_d;
   logic              ovr_q, ovr_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              txd_q, txd_d;

   logic              baud_en;
   logic              restart;
   logic              bit_end;
   logic              load;
   logic [7:0]        shift_adv;
   logic              head_bit;

   spart_brg #(
      .DIV_W (DIV_W)
   ) u_brg (
      .clk     (clk),
      .rst     (rst),
      .divisor (divisor),
      .restart (restart),
      .baud_en (baud_en)
   );

   // Bit order only changes which end of the shift register goes out first.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign shift_adv = {shift_q[6:0], 1'b0};
         assign head_bit  = shift_d[7];
      end else begin : g_lsb_first
         assign shift_adv = {1'b0, shift_q[7:1]};
         assign head_bit  = shift_d[0];
      end
   endgenerate

   // The sixteenth enable of a bit time ends that bit.
   assign bit_end = baud_en && (tick_q == TICK_LAST);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         buf_q   <= '0;
         full_q  <= 1'b0;
         ovr_q   <= 1'b0;
         tick_q  <= '0;
         bit_q   <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         buf_q   <= buf_d;
         full_q  <= full_d;
         ovr_q   <= ovr_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         txd_q   <= txd_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      buf_d   = buf_q;
      full_d  = full_q;
      ovr_d   = ovr_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      load    = 1'b0;

      // A write is only accepted into an empty buffer. A buffer that is
      // consumed this cycle still counts as full, so nothing bypasses it.
      if (tx_wr && !full_q) begin
         buf_d  = tx_data;
         full_d = 1'b1;
      end

      // If a clear and an overrun happen together, the overrun wins.
      if (ovr_clr) begin
         ovr_d = 1'b0;
      end
      if (tx_wr && full_q) begin
         ovr_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (full_q) begin
               state_d = START;
               load    = 1'b1;
            end
         end
         START: begin
            if (baud_en) begin
               tick_d = tick_q + TICK_W'(1);
            end
            if (bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_en) begin
               tick_d = tick_q + TICK_W'(1);
            end
            if (bit_end) begin
               shift_d = shift_adv;
               bit_d   = bit_q + BIT_W'(1);
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (baud_en) begin
               tick_d = tick_q + TICK_W'(1);
            end
            if (bit_end) begin
               if (full_q) begin
                  state_d = START;
                  load    = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load) begin
         shift_d = buf_q;
         full_d  = 1'b0;
         tick_d  = '0;
         bit_d   = '0;
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      // Only the IDLE->START move needs a forced reload. A STOP->START move
      // already happens on a counter reload.
      restart = (state_q == IDLE) && full_q;

      // txd comes from the next state, so the registered line changes on
      // the same edge as the FSM.
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = head_bit;
         default: txd_d = 1'b1;
      endcase
   end

   assign tbr     = !full_q;
   assign tx_busy = (state_q != IDLE);
   assign tx_ovr  = ovr_q;
   assign txd     = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_spart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spart_tx_serializer
// Description : Directed bench for spart_tx_serializer. It runs an LSB-first
//               and an MSB-first instance side by side on the same inputs.
//               Each frame is checked on the first and last clock of every
//               bit time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_tx_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] divisor = 16'd4;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_wr = 1'b0;
   logic        ovr_clr = 1'b0;

   logic tbr_l, busy_l, ovr_l, txd_l;
   logic tbr_m, busy_m, ovr_m, txd_m;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spart_tx_serializer #(.DIV_W(16), .MSB_FIRST(1'b0)) dut_lsb (
      .clk     (clk),
      .rst     (rst),
      .divisor (divisor),
      .tx_data (tx_data),
      .tx_wr   (tx_wr),
      .tbr     (tbr_l),
      .tx_busy (busy_l),
      .tx_ovr  (ovr_l),
      .ovr_clr (ovr_clr),
      .txd     (txd_l)
   );

   spart_tx_serializer #(.DIV_W(16), .MSB_FIRST(1'b1)) dut_msb (
      .clk     (clk),
      .rst     (rst),
      .divisor (divisor),
      .tx_data (tx_data),
      .tx_wr   (tx_wr),
      .tbr     (tbr_m),
      .tx_busy (busy_m),
      .tx_ovr  (ovr_m),
      .ovr_clr (ovr_clr),
      .txd     (txd_m)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [7:0] d);
      tx_wr   = 1'b1;
      tx_data = d;
      tick();
      tx_wr   = 1'b0;
   endtask

   // Call this 1 time unit after the edge that starts the start bit.
   // Optional writes are issued during the start bit.
   task automatic check_frame(input string tag, input logic [7:0] d, input int bitlen,
                              input int n_wr, input logic [7:0] nxt, input logic [7:0] extra,
                              input bit expect_next);
      logic exp_l, exp_m;
      int   used;
      for (int k = 0; k < 10; k++) begin
         if (k == 0) begin
            exp_l = 1'b0;
            exp_m = 1'b0;
         end else if (k == 9) begin
            exp_l = 1'b1;
            exp_m = 1'b1;
         end else begin
            exp_l = d[k-1];
            exp_m = d[8-k];
         end
         check($sformatf("%s_b%0d_first_lsb", tag, k), txd_l, exp_l);
         check($sformatf("%s_b%0d_first_msb", tag, k), txd_m, exp_m);
         check($sformatf("%s_b%0d_busy", tag, k), busy_l, 1);
         used = 0;
         if (k == 0 && n_wr >= 1) begin
            wr_byte(nxt);
            used++;
            check($sformatf("%s_wr1_tbr", tag), tbr_l, 0);
            if (n_wr >= 2) begin
               wr_byte(extra);
               used++;
               check($sformatf("%s_wr2_ovr", tag), ovr_l, 1);
               check($sformatf("%s_wr2_tbr", tag), tbr_l, 0);
            end
         end
         repeat (bitlen - 1 - used) tick();
         check($sformatf("%s_b%0d_last_lsb", tag, k), txd_l, exp_l);
         check($sformatf("%s_b%0d_last_msb", tag, k), txd_m, exp_m);
         tick();
      end
      if (expect_next) begin
         check($sformatf("%s_next_start", tag), txd_l, 0);
         check($sformatf("%s_next_busy", tag), busy_l, 1);
      end else begin
         check($sformatf("%s_end_idle", tag), txd_l, 1);
         check($sformatf("%s_end_busy", tag), busy_l, 0);
      end
   endtask

   initial begin
      // Reset with no traffic: the line must stay idle.
      repeat (3) tick();
      rst = 1'b0;
      check("rst_ovr", ovr_l, 0);
      for (int i = 0; i < 200; i++) begin
         check("idle_txd", txd_l, 1);
         check("idle_tbr", tbr_l, 1);
         check("idle_busy", busy_l, 0);
         tick();
      end

      // Single frame 0x68 at divisor 4 (80-clock bits).
      wr_byte(8'h68);
      check("f68_tbr_after_wr", tbr_l, 0);
      check("f68_txd_after_wr", txd_l, 1);
      check("f68_busy_after_wr", busy_l, 0);
      tick();
      check("f68_tbr_released", tbr_l, 1);
      check_frame("f68", 8'h68, 80, 0, 8'h00, 8'h00, 1'b0);

      // Back-to-back frames: 0x3C is queued during the start bit of 0xA5.
      wr_byte(8'hA5);
      tick();
      check_frame("b2b_a5", 8'hA5, 80, 1, 8'h3C, 8'h00, 1'b1);
      check_frame("b2b_3c", 8'h3C, 80, 0, 8'h00, 8'h00, 1'b0);

      // Overrun: 0x33 is written while the buffer holds 0x22 and is dropped.
      wr_byte(8'h11);
      tick();
      check_frame("ovr_11", 8'h11, 80, 2, 8'h22, 8'h33, 1'b1);
      check_frame("ovr_22", 8'h22, 80, 0, 8'h00, 8'h00, 1'b0);
      check("ovr_sticky", ovr_l, 1);
      tick();
      check("ovr_still_idle", txd_l, 1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      check("ovr_cleared", ovr_l, 0);

      // Divisor 0. A write arrives in the cycle that the buffer is consumed,
      // together with a clear, so the overrun sets.
      divisor = 16'd0;
      tick();
      wr_byte(8'h08);
      check("d0_tbr_after_wr", tbr_l, 0);
      tx_wr   = 1'b1;
      tx_data = 8'h99;
      ovr_clr = 1'b1;
      tick();
      tx_wr   = 1'b0;
      ovr_clr = 1'b0;
      check("d0_set_wins", ovr_l, 1);
      check("d0_no_bypass_tbr", tbr_l, 1);
      check("d0_start", txd_l, 0);
      // Reset during data bit 3 (frame bit index 4, 16-clock bits).
      repeat (69) tick();
      check("d0_bit3_lsb", txd_l, 1);
      check("d0_bit3_msb", txd_m, 0);
      rst = 1'b1;
      tick();
      check("rst_mid_txd", txd_l, 1);
      check("rst_mid_txd_msb", txd_m, 1);
      check("rst_mid_tbr", tbr_l, 1);
      check("rst_mid_busy", busy_l, 0);
      check("rst_mid_ovr", ovr_l, 0);
      rst = 1'b0;
      tick();
      check("post_rst_idle", txd_l, 1);
      check("post_rst_busy", busy_l, 0);
      wr_byte(8'hC3);
      tick();
      check("c3_tbr", tbr_l, 1);
      check_frame("c3", 8'hC3, 16, 0, 8'h00, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spart_tx_serializer.md
Name: spart_tx_serializer

Overview:
- Standalone SPART transmit serializer: accepts a byte from the bus-side driver and shifts it out on a serial txd line as an 8N1 frame (1 start bit, 8 data bits, 1 stop bit).
- Counterpart of the receive path the SPART benches drive on rxd. Provides a one-byte holding buffer so the driver can queue the next character while the current one is shifting.
- Bit timing comes from a 16x-oversampled baud enable, using the same divisor semantics as the SPART baud configuration.

Parameters:
- DIV_W, 16, width of baud divisor input.
- MSB_FIRST, 0, 0 = LSB sent first (standard UART); 1 = MSB sent first.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- divisor  input  DIV_W  baud enable fires every divisor+1 clocks; one bit = 16 enables
- tx_data  input  8  byte to transmit
- tx_wr  input  1  single-cycle write strobe for tx_data
- tbr  output  1  transmit buffer ready (holding buffer empty)
- tx_busy  output  1  frame in progress (FSM not IDLE)
- tx_ovr  output  1  sticky overrun: write attempted while tbr=0
- ovr_clr  input  1  clears tx_ovr
- txd  output  1  serial output, idle high

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: txd=1, tbr=1, tx_busy=0, tx_ovr=0, FSM=IDLE, all counters=0, holding buffer empty.
- Holding buffer:
  - tx_wr with tbr=1 latches tx_data and sets tbr=0 at that edge.
  - tx_wr with tbr=0 is ignored: data is dropped and tx_ovr is set.
  - ovr_clr clears tx_ovr. If ovr_clr and an overrun occur in the same cycle, set wins.
- Baud enable (sub-module):
  - Down-counter reloads to divisor when it reaches 0 and pulses baud_en for one cycle at that point.
  - Forced to reload to divisor on the IDLE->START transition, so every bit lasts exactly 16*(divisor+1) clocks.
  - A divisor change takes effect at the next reload.
  - divisor=0 gives baud_en every clock (16-clock bits).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If buffer full, move to START on the next edge; copy buffer to shift register, clear buffer (tbr=1), zero the tick and bit counters.
  - START: txd=0. After 16 baud_en pulses (tick counter 15->0 wrap), go to DATA.
  - DATA: txd = shift[0] (or shift[7] when MSB_FIRST). Every 16 baud_en pulses, shift and increment the bit counter. After bit 7 completes, go to STOP.
  - STOP: txd=1 for 16 baud_en pulses, then return to IDLE.
  - Back-to-back frames: if the buffer is full at STOP completion, go directly to START (no idle bit). Frames are contiguous: exactly 10 bit times apart.
- Latency: a tx_wr at edge N (FSM idle) puts txd low from edge N+1. tbr returns to 1 after edge N+1.
- tx_wr in the same cycle that the buffer is consumed (IDLE->START, or STOP->START): the buffer is considered empty only after that edge. The write is accepted only if tbr=1 in the strobe cycle. No bypass.
- txd is driven directly from a register (glitch-free).
- Reset mid-frame: txd returns to 1 on the next edge, the frame is aborted, and buffered data is discarded.
- tx_busy = (FSM != IDLE).

Decomposition:
- Shared package spart_pkg:
  - enum tx_state_t {IDLE, START, DATA, STOP}
  - localparam OVERSAMPLE=16
  - localparam DATA_BITS=8
- Sub-module spart_brg: baud enable generator with ports clk, rst, divisor, restart, baud_en. It is reusable by the receive side.

Test Plan:
- Reset with divisor=4, no writes for 200 clocks -> txd=1, tbr=1, tx_busy=0 throughout.
- divisor=4, write 0x68 -> txd low 80 clocks; data bits LSB-first 0,0,0,1,0,1,1,0 at 80 clocks each; stop high 80 clocks; total frame 800 clocks; tbr=1 one edge after the write.
- MSB_FIRST=1, divisor=4, write 0x68 -> data bits 0,1,1,0,1,0,0,0, each 80 clocks.
- Write 0xA5 then 0x3C as soon as tbr=1 -> two contiguous frames, 1600 clocks total, no idle gap; tx_busy held high the entire time.
- Write 0x11, then 0x22 while tbr=1, then 0x33 while tbr=0 -> 0x33 dropped, tx_ovr=1 until ovr_clr pulse; only 0x11 and 0x22 appear on txd.
- Assert rst mid-DATA (bit 3) of a frame with divisor=0 -> txd=1, tbr=1, tx_busy=0 on the next edge; a new write afterwards produces a clean frame with 16-clock bits.
